comp_unit: RTL and testbench

COMP_UNIT -- requirements
Module: comp_unit

---
 rtl/comp_unit.sv | 117 +++++++++++
 tb/tb_comp_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_unit.sv
// Single-operand unary ALU (pass / ones / twos / abs) feeding a 2-entry in-order result buffer.
// Optional COMP_UNIT_SAT_EN: saturate the most-negative negation overflow to the most-positive value.
module comp_unit #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] A,
  input  logic [BUS_WIDTH-1:0] B,
  input  logic                 operand_flag,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] Y,
  output logic                 zero_flag,
  output logic                 ovf_flag
);

  localparam logic [BUS_WIDTH-1:0] MIN_VAL = {1'b1, {(BUS_WIDTH-1){1'b0}}};

  logic [BUS_WIDTH-1:0] ent_y [2];
  logic                 ent_z [2];
  logic                 ent_o [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;

  logic [BUS_WIDTH-1:0] x_sel;
  logic [BUS_WIDTH-1:0] x_neg;
  logic [BUS_WIDTH-1:0] res_y;
  logic                 res_z;
  logic                 res_o;
  logic                 push;
  logic                 pop;
  logic                 rd_nx;
  logic [1:0]           count_nx;
  logic [BUS_WIDTH-1:0] head_y;
  logic                 head_z;
  logic                 head_o;

  always_comb begin
    x_sel = operand_flag ? A : B;
    x_neg = ~x_sel + {{(BUS_WIDTH-1){1'b0}}, 1'b1};
    res_o = mode[1] && (x_sel == MIN_VAL);
    case (mode)
      2'b00:   res_y = x_sel;
      2'b01:   res_y = ~x_sel;
      2'b10:   res_y = x_neg;
      default: res_y = x_sel[BUS_WIDTH-1] ? x_neg : x_sel;
    endcase
`ifdef COMP_UNIT_SAT_EN
    if (res_o)
      res_y = ~MIN_VAL;
`endif
    res_z = (res_y == '0);
  end

  always_comb begin
    push  = in_valid && in_ready;
    pop   = out_valid && out_ready;
    rd_nx = rd_ptr ^ pop;
    case ({push, pop})
      2'b10:   count_nx = count + 2'd1;
      2'b01:   count_nx = count - 2'd1;
      default: count_nx = count;
    endcase
    // The next head may be the entry being written on this same edge.
    if (push && (wr_ptr == rd_nx)) begin
      head_y = res_y;
      head_z = res_z;
      head_o = res_o;
    end else begin
      head_y = ent_y[rd_nx];
      head_z = ent_z[rd_nx];
      head_o = ent_o[rd_nx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_y[0]  <= '0;
      ent_y[1]  <= '0;
      ent_z[0]  <= 1'b0;
      ent_z[1]  <= 1'b0;
      ent_o[0]  <= 1'b0;
      ent_o[1]  <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      Y         <= '0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      if (push) begin
        ent_y[wr_ptr] <= res_y;
        ent_z[wr_ptr] <= res_z;
        ent_o[wr_ptr] <= res_o;
        wr_ptr        <= ~wr_ptr;
      end
      rd_ptr    <= rd_nx;
      count     <= count_nx;
      in_ready  <= (count_nx != 2'd2);
      out_valid <= (count_nx != 2'd0);
      // Empty buffer keeps presenting the last popped result.
      if (count_nx != 2'd0) begin
        Y         <= head_y;
        zero_flag <= head_z;
        ovf_flag  <= head_o;
      end
    end
  end

endmodule

// File: tb/tb_comp_unit.sv
// Directed self-checking bench for comp_unit (8-bit), default or COMP_UNIT_SAT_EN build.
module tb_comp_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       operand_flag = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] Y;
  logic       zero_flag;
  logic       ovf_flag;

  int checks = 0;
  int errors = 0;

  comp_unit #(.BUS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .operand_flag(operand_flag), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .Y(Y),
    .zero_flag(zero_flag), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({out_valid, in_ready, zero_flag, ovf_flag} !== 4'b0000 || Y !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: valid=%b rdy=%b Y=%h z=%b o=%b, expected all 0", out_valid, in_ready, Y, zero_flag, ovf_flag);
    end
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b expected 0 before first edge", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_ones;
    out_ready = 1'b1;
    A = 8'h5A; B = 8'h00; operand_flag = 1'b1; mode = 2'b01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Y !== 8'hA5 || zero_flag !== 1'b0 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL ones_5a: valid=%b Y=%h z=%b o=%b expected 1 a5 0 0", out_valid, Y, zero_flag, ovf_flag);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || Y !== 8'hA5) begin
      errors++;
      $display("FAIL empty_hold: valid=%b Y=%h expected 0 a5", out_valid, Y);
    end
  endtask

  task automatic test_twos_pass;
    out_ready = 1'b1;
    B = 8'h01; A = 8'h33; operand_flag = 1'b0; mode = 2'b10; in_valid = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || Y !== 8'hFF || zero_flag !== 1'b0 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL twos_01: valid=%b Y=%h z=%b o=%b expected 1 ff 0 0", out_valid, Y, zero_flag, ovf_flag);
    end
    B = 8'h00; mode = 2'b00;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Y !== 8'h00 || zero_flag !== 1'b1 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL pass_zero: valid=%b Y=%h z=%b o=%b expected 1 00 1 0", out_valid, Y, zero_flag, ovf_flag);
    end
    step();
  endtask

  task automatic test_abs;
    logic [7:0] exp_min;
`ifdef COMP_UNIT_SAT_EN
    exp_min = 8'h7F;
`else
    exp_min = 8'h80;
`endif
    out_ready = 1'b1;
    A = 8'h80; operand_flag = 1'b1; mode = 2'b11; in_valid = 1'b1;
    step();
    checks++;
    if (Y !== exp_min || ovf_flag !== 1'b1 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL abs_min: Y=%h o=%b z=%b expected %h 1 0", Y, ovf_flag, zero_flag, exp_min);
    end
    A = 8'hF6;
    step();
    checks++;
    if (Y !== 8'h0A || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL abs_f6: Y=%h o=%b expected 0a 0", Y, ovf_flag);
    end
    A = 8'h80; mode = 2'b10;
    step();
    checks++;
    if (Y !== exp_min || ovf_flag !== 1'b1) begin
      errors++;
      $display("FAIL twos_min: Y=%h o=%b expected %h 1", Y, ovf_flag, exp_min);
    end
    mode = 2'b01;
    step();
    checks++;
    if (Y !== 8'h7F || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL ones_min_noovf: Y=%h o=%b expected 7f 0", Y, ovf_flag);
    end
    A = 8'h25; mode = 2'b11;
    step();
    in_valid = 1'b0;
    checks++;
    if (Y !== 8'h25 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL abs_pos: Y=%h o=%b expected 25 0", Y, ovf_flag);
    end
    step();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    operand_flag = 1'b1; mode = 2'b00; in_valid = 1'b1;
    A = 8'h01;
    step();
    A = 8'h02;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || Y !== 8'h01) begin
      errors++;
      $display("FAIL bp_full: rdy=%b valid=%b Y=%h expected 0 1 01", in_ready, out_valid, Y);
    end
    A = 8'h03; mode = 2'b01;
    step();
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || Y !== 8'h01 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall_hold: rdy=%b Y=%h z=%b expected 0 01 0", in_ready, Y, zero_flag);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || Y !== 8'h02 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain1: valid=%b Y=%h rdy=%b expected 1 02 1", out_valid, Y, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || Y !== 8'h02) begin
      errors++;
      $display("FAIL bp_drain2: valid=%b Y=%h expected 0 02 (third request dropped)", out_valid, Y);
    end
  endtask

  task automatic test_back_to_back;
    int accepts = 0;
    int bad = 0;
    out_ready = 1'b1;
    operand_flag = 1'b1; mode = 2'b01;
    for (int i = 0; i < 16; i++) begin
      A = 8'(i * 17 + 3);
      in_valid = 1'b1;
      if (in_ready === 1'b1) accepts++;
      step();
      if (out_valid !== 1'b1 || Y !== ~(8'(i * 17 + 3))) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (accepts != 16) begin
      errors++;
      $display("FAIL stream_accepts: got %0d accepts, expected 16", accepts);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stream_order: %0d results wrong, expected 0", bad);
    end
    step();
  endtask

  task automatic test_reset_mid;
    int stale = 0;
    out_ready = 1'b0;
    operand_flag = 1'b1; mode = 2'b00; in_valid = 1'b1;
    A = 8'h11;
    step();
    A = 8'h22;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Y !== 8'h00 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b Y=%h rdy=%b expected 0 00 0", out_valid, Y, in_ready);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid !== 1'b0 || Y !== 8'h00) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL reset_stale: %0d cycles showed a result, expected 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_twos_pass();
    test_abs();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
